// File: rtl/rr_priority_encoder_pkg.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder_pkg
// Shared constants for the round-robin priority encoder slice:
//   RR_N_DEFAULT  default code width (2**N request lines)
//   RR_FIXED      ROUND_ROBIN encoding: fixed priority, lowest index wins
//   RR_ROTATE     ROUND_ROBIN encoding: rotating priority after last issue
//   CODE_RST      reset value of the presented code
//   PTR_RST       reset value of the rotation pointer
// ---------------------------------------------------------------------------
package rr_priority_encoder_pkg;

    localparam int RR_N_DEFAULT = 4;

    localparam bit RR_FIXED  = 1'b0;
    localparam bit RR_ROTATE = 1'b1;

    localparam int CODE_RST = 0;
    localparam int PTR_RST  = 0;

endpackage

// File: rtl/rr_priority_encoder_if.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder_if
// Valid/ready code channel between the encoder and the digit-select path.
//   code   N-bit binary index of the presented request (producer -> consumer)
//   valid  code is meaningful                          (producer -> consumer)
//   ready  consumer accepts code on valid && ready      (consumer -> producer)
// Modports: master = encoder side, slave = consumer side.
// ---------------------------------------------------------------------------
interface rr_priority_encoder_if #(
    parameter int N = rr_priority_encoder_pkg::RR_N_DEFAULT
) ();

    logic [N-1:0] code;
    logic         valid;
    logic         ready;

    modport master (
        output code,
        output valid,
        input  ready
    );

    modport slave (
        input  code,
        input  valid,
        output ready
    );

endinterface

// File: rtl/rr_priority_encoder_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating find-first over 2**N candidate bits.
//   cand  2**N  candidate request vector
//   ptr   N     index where the scan starts (wraps modulo 2**N)
//   any   1     at least one candidate bit is set
//   sel   N     index of the first set bit at or after ptr
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N = rr_priority_encoder_pkg::RR_N_DEFAULT
) (
    input  logic [2**N-1:0] cand,
    input  logic [N-1:0]    ptr,
    output logic            any,
    output logic [N-1:0]    sel
);

    localparam int W = 2**N;

    // Two copies back to back: scanning from ptr upward through the doubled
    // vector visits ptr..W-1 and then 0..ptr-1 without a wrap compare.
    logic [2*W-1:0] dbl;

    assign dbl = {cand, cand};

    always_comb begin
        any = 1'b0;
        sel = '0;
        for (int j = 0; j < 2*W; j++) begin
            if (!any && (j >= int'(ptr)) && dbl[j]) begin
                any = 1'b1;
                sel = j[N-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder
// Captures 2**N request lines as sticky pending bits, picks one (round-robin
// or fixed priority) and presents its index as a registered code held until
// a valid/ready handshake completes.
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   req      2**N level-sampled request lines
//   bus      code/valid/ready channel (master modport)
//   pending  registered sticky pending vector, issued bits excluded
//   overflow sticky merged-event flag, present only with
//            RR_PRIO_ENC_OVERFLOW_EN defined
// ---------------------------------------------------------------------------
module rr_priority_encoder
    import rr_priority_encoder_pkg::*;
#(
    parameter int N           = RR_N_DEFAULT,
    parameter bit ROUND_ROBIN = RR_ROTATE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2**N-1:0]      req,
    rr_priority_encoder_if.master bus,
`ifdef RR_PRIO_ENC_OVERFLOW_EN
    output logic                 overflow,
`endif
    output logic [2**N-1:0]      pending
);

    localparam int W = 2**N;

    logic [N-1:0] code_q;
    logic         valid_q;
    logic [W-1:0] pending_q;
    logic [N-1:0] ptr_q;

    logic [W-1:0] cand;
    logic         load;
    logic [N-1:0] scan_start;
    logic         any;
    logic [N-1:0] sel;
    logic [W-1:0] sel_mask;
    logic [W-1:0] issue_mask;

    assign cand       = pending_q | req;
    assign load       = !valid_q || bus.ready;
    assign scan_start = (ROUND_ROBIN == RR_ROTATE) ? ptr_q : N'(0);
    assign sel_mask   = W'(1) << sel;
    // Only a bit actually loaded this edge counts as issued.
    assign issue_mask = (load && any) ? sel_mask : '0;

    rr_pick #(.N(N)) u_pick (
        .cand (cand),
        .ptr  (scan_start),
        .any  (any),
        .sel  (sel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q    <= N'(CODE_RST);
            valid_q   <= 1'b0;
            pending_q <= '0;
            ptr_q     <= N'(PTR_RST);
        end else if (load) begin
            if (any) begin
                code_q    <= sel;
                valid_q   <= 1'b1;
                pending_q <= cand & ~sel_mask;
                ptr_q     <= sel + N'(1);
            end else begin
                valid_q   <= 1'b0;
                pending_q <= '0;
            end
        end else begin
            pending_q <= cand;
        end
    end

`ifdef RR_PRIO_ENC_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (|(req & pending_q & ~issue_mask)) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_issue;
    assign unused_issue = ^issue_mask;
`endif

    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_priority_encoder
// Directed bench for rr_priority_encoder at N=2 (4 request lines). A rotating
// instance and a fixed-priority instance share req/reset/ready.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_priority_encoder;

    localparam int N = 2;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] req = '0;
    logic [W-1:0] pend_rr;
    logic [W-1:0] pend_fx;
`ifdef RR_PRIO_ENC_OVERFLOW_EN
    logic         ovf_rr;
    logic         ovf_fx;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    rr_priority_encoder_if #(.N(N)) bus_rr ();
    rr_priority_encoder_if #(.N(N)) bus_fx ();

    rr_priority_encoder #(.N(N), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .bus      (bus_rr),
`ifdef RR_PRIO_ENC_OVERFLOW_EN
        .overflow (ovf_rr),
`endif
        .pending  (pend_rr)
    );

    rr_priority_encoder #(.N(N), .ROUND_ROBIN(1'b0)) dut_fx (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .bus      (bus_fx),
`ifdef RR_PRIO_ENC_OVERFLOW_EN
        .overflow (ovf_fx),
`endif
        .pending  (pend_fx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        bus_rr.ready = 1'b1;
        bus_fx.ready = 1'b1;
        #3;
        reset_n = 1'b1;
        #1;
        chk("rst_valid", 32'(bus_rr.valid), 0);
        chk("rst_code",  32'(bus_rr.code), 0);
        chk("rst_pend",  32'(pend_rr), 0);

        // single request, immediate issue then handshake
        req = 4'b0100;
        tick();
        chk("t1_valid", 32'(bus_rr.valid), 1);
        chk("t1_code",  32'(bus_rr.code), 2);
        chk("t1_pend",  32'(pend_rr), 0);
        req = 4'b0000;
        tick();
        chk("t1_idle_valid", 32'(bus_rr.valid), 0);
        chk("t1_idle_pend",  32'(pend_rr), 0);
        chk("t1_code_hold",  32'(bus_rr.code), 2);

        // stalled multi-request, then drain with no bubble
        do_reset();
        bus_rr.ready = 1'b0;
        bus_fx.ready = 1'b0;
        req = 4'b1011;
        tick();
        req = 4'b0000;
        chk("t2_c0_code", 32'(bus_rr.code), 0);
        chk("t2_c0_pend", 32'(pend_rr), 32'b1010);
        tick();
        tick();
        chk("t2_hold_code",  32'(bus_rr.code), 0);
        chk("t2_hold_valid", 32'(bus_rr.valid), 1);
        chk("t2_hold_pend",  32'(pend_rr), 32'b1010);
        bus_rr.ready = 1'b1;
        bus_fx.ready = 1'b1;
        tick();
        chk("t2_c1_code",  32'(bus_rr.code), 1);
        chk("t2_c1_valid", 32'(bus_rr.valid), 1);
        chk("t2_c1_pend",  32'(pend_rr), 32'b1000);
        tick();
        chk("t2_c3_code",  32'(bus_rr.code), 3);
        chk("t2_c3_valid", 32'(bus_rr.valid), 1);
        chk("t2_c3_pend",  32'(pend_rr), 0);
        tick();
        chk("t2_end_valid", 32'(bus_rr.valid), 0);

        // all lines held: rotate with wrap, fixed stays on 0
        do_reset();
        req = 4'b1111;
        tick();
        chk("t3_rr0", 32'(bus_rr.code), 0);
        chk("t3_fx0", 32'(bus_fx.code), 0);
        chk("t3_rr_pend0", 32'(pend_rr), 32'b1110);
        tick();
        chk("t3_rr1", 32'(bus_rr.code), 1);
        chk("t3_fx1", 32'(bus_fx.code), 0);
        chk("t3_rr_pend1", 32'(pend_rr), 32'b1101);
        tick();
        chk("t3_rr2", 32'(bus_rr.code), 2);
        chk("t3_fx2", 32'(bus_fx.code), 0);
        tick();
        chk("t3_rr3", 32'(bus_rr.code), 3);
        chk("t3_fx3", 32'(bus_fx.code), 0);
        tick();
        chk("t3_rr_wrap0", 32'(bus_rr.code), 0);
        chk("t3_fx4", 32'(bus_fx.code), 0);
        chk("t3_fx_pend", 32'(pend_fx), 32'b1110);
        tick();
        chk("t3_rr_wrap1", 32'(bus_rr.code), 1);
        chk("t3_rr_valid", 32'(bus_rr.valid), 1);
        req = 4'b0000;

        // pulse on bit 3 during a stall on code 1 is kept and issued
        do_reset();
        bus_rr.ready = 1'b0;
        bus_fx.ready = 1'b0;
        req = 4'b0010;
        tick();
        chk("t4_code1", 32'(bus_rr.code), 1);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        chk("t4_pend3", 32'(pend_rr), 32'b1000);
        tick();
        chk("t4_pend3_hold", 32'(pend_rr), 32'b1000);
        chk("t4_code1_hold", 32'(bus_rr.code), 1);
        bus_rr.ready = 1'b1;
        bus_fx.ready = 1'b1;
        tick();
        chk("t4_code3",  32'(bus_rr.code), 3);
        chk("t4_valid3", 32'(bus_rr.valid), 1);
        chk("t4_pend0",  32'(pend_rr), 0);
        tick();
        chk("t4_idle", 32'(bus_rr.valid), 0);

        // merged events while stalled, then async reset mid-stall
        do_reset();
        bus_rr.ready = 1'b0;
        bus_fx.ready = 1'b0;
        req = 4'b0001;
        tick();
        req = 4'b0100;
        tick();
        chk("t5_pend2", 32'(pend_rr), 32'b0100);
`ifdef RR_PRIO_ENC_OVERFLOW_EN
        chk("t5_ovf_first", 32'(ovf_rr), 0);
`endif
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("t5_pend2_merged", 32'(pend_rr), 32'b0100);
`ifdef RR_PRIO_ENC_OVERFLOW_EN
        chk("t5_ovf_set", 32'(ovf_rr), 1);
        tick();
        chk("t5_ovf_sticky", 32'(ovf_rr), 1);
`endif
        reset_n = 1'b0;
        #1;
        chk("t5_arst_valid", 32'(bus_rr.valid), 0);
        chk("t5_arst_pend",  32'(pend_rr), 0);
        chk("t5_arst_code",  32'(bus_rr.code), 0);
`ifdef RR_PRIO_ENC_OVERFLOW_EN
        chk("t5_arst_ovf",   32'(ovf_rr), 0);
`endif
        #2;
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, required finish before 20000ns");
        $fatal(1, "timeout");
    end

endmodule
